// File: rtl/ctrl_sequencer.sv
// Purpose : multi-cycle fetch/decode/execute sequencer driving ALU control, RF addresses,
//           PC strobes and the instruction/data memory request handshakes.
// Latency : ALU op = fetch wait + 4 cycles, JMP/NOP = +3, ST = +3 + mem wait, LD = +4 + mem wait.
// Backpressure: stalls in FETCH until imem_ack and in MEM until dmem_ack or DMEM_TIMEOUT cycles.
//
// Optional feature macro: ILLEGAL_TRAP_EN
//   defined   : reserved opcodes (1001/1110/1111) halt in HALT with trap=1 until reset.
//   undefined : reserved opcodes behave as NOP; trap is tied 0 and HALT is unreachable.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   imem_req / imem_ack, instr instruction fetch handshake and word
//   dmem_req / dmem_we / dmem_ack  data memory handshake (we: 1=store)
//   alu_control, imm           ALU opcode and immediate, held from DECODE to next DECODE
//   rf_ra_addr, rf_rb_addr     register-file read addresses, held like alu_control
//   rf_we, rf_waddr, wb_sel    register-file writeback (wb_sel: 0=ALU, 1=memory)
//   pc_inc, pc_load            PC strobes, exactly one per instruction
//   mem_err, trap              sticky data-memory timeout flag, illegal-opcode halt flag
//   state_o                    current FSM state for debug
module ctrl_sequencer #(
  parameter int IW           = 24,
  parameter int RAW          = 4,
  parameter int DMEM_TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  output logic           imem_req,
  input  logic           imem_ack,
  input  logic [IW-1:0]  instr,
  output logic           dmem_req,
  output logic           dmem_we,
  input  logic           dmem_ack,
  output logic [3:0]     alu_control,
  output logic [7:0]     imm,
  output logic [RAW-1:0] rf_ra_addr,
  output logic [RAW-1:0] rf_rb_addr,
  output logic           rf_we,
  output logic [RAW-1:0] rf_waddr,
  output logic           wb_sel,
  output logic           pc_inc,
  output logic           pc_load,
  output logic           mem_err,
  output logic           trap,
  output logic [2:0]     state_o
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [3:0] OP_JMP  = 4'b0111;
  localparam logic [3:0] OP_NOP  = 4'b1000;
  localparam logic [3:0] OP_LD   = 4'b1010;
  localparam logic [3:0] OP_ST   = 4'b1011;
  localparam logic [3:0] OP_AGEN = 4'b1100;  // ALU add used for Ra + imm address generation

  localparam int CW = 8;
  localparam logic [CW-1:0] TO_LAST = CW'(DMEM_TIMEOUT - 1);

  state_e          state_q, state_d;
  logic [IW-1:0]   ir_q;
  logic [3:0]      alu_q, alu_d;
  logic [7:0]      imm_q, imm_d;
  logic [RAW-1:0]  ra_q, ra_d;
  logic [RAW-1:0]  rb_q, rb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            mem_err_q, mem_err_d;

  // Instruction fields, always taken from the registered instruction.
  logic [3:0]      op;
  logic [RAW-1:0]  f_ry, f_ra, f_rb;
  logic            op_rsv;
  logic            mem_tout;

  assign op     = ir_q[IW-1 -: 4];
  assign f_ry   = ir_q[16 +: RAW];
  assign f_ra   = ir_q[12 +: RAW];
  assign f_rb   = ir_q[8 +: RAW];
  assign op_rsv = (op == 4'b1001) || (op == 4'b1110) || (op == 4'b1111);

  // Current MEM cycle is the last one allowed before giving up on the ack.
  assign mem_tout = (cnt_q == TO_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  if (imem_ack) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (op == OP_JMP || op == OP_NOP) begin
          state_d = S_FETCH;
        end else if (op == OP_LD || op == OP_ST) begin
          state_d = S_MEM;
        end else if (op_rsv) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_HALT;
`else
          state_d = S_FETCH;
`endif
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (dmem_ack) begin
          state_d = (op == OP_LD) ? S_WB : S_FETCH;
        end else if (mem_tout) begin
          state_d = S_FETCH;
        end
      end
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath holding registers: instruction, decoded controls, MEM counter, error flag
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_d     = alu_q;
    imm_d     = imm_q;
    ra_d      = ra_q;
    rb_d      = rb_q;
    mem_err_d = mem_err_q;
    cnt_d     = '0;

    if (state_q == S_DECODE) begin
      alu_d = (op == OP_LD || op == OP_ST) ? OP_AGEN : op;
      imm_d = ir_q[7:0];
      ra_d  = f_ra;
      rb_d  = f_rb;
    end

    if (state_q == S_MEM) begin
      if (state_d == S_MEM) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (!dmem_ack && mem_tout) begin
        mem_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir_q      <= '0;
      alu_q     <= OP_NOP;
      imm_q     <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      if (state_q == S_FETCH && imem_ack) begin
        ir_q <= instr;
      end
      alu_q     <= alu_d;
      imm_q     <= imm_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from state and instruction register
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = '0;
    wb_sel   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    trap     = 1'b0;

    unique case (state_q)
      S_FETCH: imem_req = 1'b1;
      S_EXEC: begin
        if (op == OP_JMP) begin
          pc_load = 1'b1;
        end else if (op == OP_NOP) begin
          pc_inc = 1'b1;
        end else if (op_rsv) begin
`ifdef ILLEGAL_TRAP_EN
          pc_inc = 1'b0;
`else
          pc_inc = 1'b1;
`endif
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        // Store completes here; an abandoned access also advances the PC here.
        pc_inc   = (dmem_ack && op == OP_ST) || (!dmem_ack && mem_tout);
      end
      S_WB: begin
        rf_we    = 1'b1;
        pc_inc   = 1'b1;
        wb_sel   = (op == OP_LD);
        rf_waddr = (op == OP_LD) ? f_rb : f_ry;
      end
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        trap = 1'b1;
`else
        trap = 1'b0;
`endif
      end
      default: ;
    endcase
  end

  assign alu_control = alu_q;
  assign imm         = imm_q;
  assign rf_ra_addr  = ra_q;
  assign rf_rb_addr  = rb_q;
  assign mem_err     = mem_err_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Purpose : self-checking bench for ctrl_sequencer; a transaction-level model expands each
//           instruction into its expected per-cycle output trace, compared every cycle.
// Ports   : none (top-level bench).
module tb_ctrl_sequencer;

  localparam int TO = 255;
`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  typedef struct packed {
    logic [2:0] st;
    logic       ireq, dreq, we;
    logic [3:0] alu;
    logic [7:0] imm;
    logic [3:0] ra, rb;
    logic       rfwe;
    logic [3:0] wa;
    logic       wbs, inc, ld, err, trap;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ack = 1'b0, dmem_ack = 1'b0;
  logic [23:0] instr = '0;
  logic        imem_req, dmem_req, dmem_we, rf_we, wb_sel, pc_inc, pc_load, mem_err, trap;
  logic [3:0]  alu_control, rf_ra_addr, rf_rb_addr, rf_waddr;
  logic [7:0]  imm;
  logic [2:0]  state_o;

  ctrl_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_ack(imem_ack), .instr(instr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_control(alu_control), .imm(imm),
    .rf_ra_addr(rf_ra_addr), .rf_rb_addr(rf_rb_addr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .wb_sel(wb_sel),
    .pc_inc(pc_inc), .pc_load(pc_load), .mem_err(mem_err), .trap(trap),
    .state_o(state_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  obs_t exp_q[$];
  obs_t act;
  assign act = {state_o, imem_req, dmem_req, dmem_we, alu_control, imm, rf_ra_addr,
                rf_rb_addr, rf_we, rf_waddr, wb_sel, pc_inc, pc_load, mem_err, trap};

  // Architectural state the model carries between instructions.
  logic [3:0] m_alu, m_ra, m_rb;
  logic [7:0] m_imm;
  logic       m_err;

  // Pulse/cycle counters observed from the DUT, for per-instruction literal checks.
  int c_inc = 0, c_ld = 0, c_rfwe = 0, c_ireq = 0, c_dreq = 0, c_we = 0;
  int s_inc, s_ld, s_rfwe, s_ireq, s_dreq, s_we;
  logic [3:0] last_wa = '0;
  logic       last_ws = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      c_inc  += int'(pc_inc);
      c_ld   += int'(pc_load);
      c_rfwe += int'(rf_we);
      c_ireq += int'(imem_req);
      c_dreq += int'(dmem_req);
      c_we   += int'(dmem_we);
      if (rf_we) begin
        last_wa = rf_waddr;
        last_ws = wb_sel;
      end
    end
  end

  // Per-cycle compare against the model trace.
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle_trace t=%0t got=%h expected=%h (st %0d/%0d)", $time, act, e,
                 act.st, e.st);
      end
    end
  end

  task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask

  function automatic logic [23:0] rnd24();
    return 24'($urandom);
  endfunction

  function automatic logic nz();
    return 1'($urandom);
  endfunction

  function automatic obs_t base(input logic [2:0] st);
    obs_t r;
    r     = '0;
    r.st  = st;
    r.alu = m_alu;
    r.imm = m_imm;
    r.ra  = m_ra;
    r.rb  = m_rb;
    r.err = m_err;
    return r;
  endfunction

  task automatic model_reset();
    m_alu = 4'h8; m_imm = '0; m_ra = '0; m_rb = '0; m_err = 1'b0;
  endtask

  task automatic snap();
    s_inc = c_inc; s_ld = c_ld; s_rfwe = c_rfwe; s_ireq = c_ireq; s_dreq = c_dreq; s_we = c_we;
  endtask

  // Called at posedge+1: drive this cycle's inputs, queue the expected outputs, move on.
  task automatic tick(input logic ia, input logic [23:0] iv, input logic da, input obs_t e);
    imem_ack = ia;
    instr    = iv;
    dmem_ack = da;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One instruction: fw fetch wait cycles, dmem ack on MEM cycle md (0 = never),
  // abort_k>0 returns at the start of MEM cycle abort_k without driving it.
  task automatic run_instr(input logic [23:0] ins, input int fw, input int md,
                           input int abort_k, output bit halted);
    logic [3:0] op;
    obs_t r;
    bit ack, tout, rsv, is_mem, done;
    op = ins[23:20];
    halted = 1'b0;
    done = 1'b0;
    ack = 1'b0;
    rsv = (op == 4'h9) || (op == 4'hE) || (op == 4'hF);
    is_mem = (op == 4'hA) || (op == 4'hB);

    for (int i = 0; i < fw; i++) begin
      r = base(3'd1); r.ireq = 1'b1;
      tick(1'b0, rnd24(), nz(), r);
    end
    r = base(3'd1); r.ireq = 1'b1;
    tick(1'b1, ins, nz(), r);
    r = base(3'd2);
    tick(nz(), rnd24(), nz(), r);
    m_alu = is_mem ? 4'hC : op;
    m_imm = ins[7:0];
    m_ra  = ins[15:12];
    m_rb  = ins[11:8];

    r = base(3'd3);
    if (op == 4'h7) r.ld = 1'b1;
    else if (op == 4'h8 || (rsv && !TRAP)) r.inc = 1'b1;
    tick(nz(), rnd24(), nz(), r);

    if (rsv && TRAP) begin
      for (int i = 0; i < 6; i++) begin
        r = base(3'd6); r.trap = 1'b1;
        tick(nz(), rnd24(), nz(), r);
      end
      halted = 1'b1;
      done = 1'b1;
    end else if (op == 4'h7 || op == 4'h8 || rsv) begin
      done = 1'b1;
    end else if (is_mem) begin
      for (int k = 1; k <= TO; k++) begin
        if (k == abort_k) return;
        ack  = (k == md);
        tout = (k == TO);
        r = base(3'd4); r.dreq = 1'b1; r.we = (op == 4'hB);
        if ((op == 4'hB && ack) || (!ack && tout)) r.inc = 1'b1;
        tick(nz(), rnd24(), ack, r);
        if (!ack && tout) m_err = 1'b1;
        if (ack || tout) break;
      end
      done = (op == 4'hB) || !ack;
    end

    if (!done) begin
      r = base(3'd5); r.rfwe = 1'b1; r.inc = 1'b1;
      r.wbs = (op == 4'hA);
      r.wa  = (op == 4'hA) ? ins[11:8] : ins[19:16];
      tick(nz(), rnd24(), nz(), r);
    end
  endtask

  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    imem_ack = nz(); dmem_ack = nz(); instr = rnd24();
    exp_q.push_back(base(3'd0));
    #1 lit("idle_no_ireq", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    lit("ireq_2nd_cycle", 32'(imem_req), 32'd1);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    lit("rst_state", 32'(state_o), 32'd0);
    lit("rst_dreq", 32'(dmem_req), 32'd0);
    lit("rst_ireq", 32'(imem_req), 32'd0);
    lit("rst_alu", 32'(alu_control), 32'h8);
    lit("rst_err_trap", 32'({mem_err, trap, pc_inc, pc_load, rf_we}), 32'd0);
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_hold_state", 32'(state_o), 32'd0);
    release_reset();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit h;
    rst_n = 1'b1;
    model_reset();
    #2;
    apply_reset();

    // ADD Ry=1 Ra=2 Rb=3
    snap(); run_instr(24'h012300, 0, 0, 0, h);
    lit("add_alu", 32'(alu_control), 32'h0);
    lit("add_rfwe", 32'(c_rfwe - s_rfwe), 32'd1);
    lit("add_inc", 32'(c_inc - s_inc), 32'd1);
    lit("add_waddr_sel", 32'({last_wa, last_ws}), 32'h2);

    // LD Ra=4 Rb=5 imm=0C, ack on 3rd MEM cycle
    snap(); run_instr(24'hA0450C, 1, 3, 0, h);
    lit("ld_alu", 32'(alu_control), 32'hC);
    lit("ld_imm", 32'(imm), 32'h0C);
    lit("ld_ra", 32'(rf_ra_addr), 32'h4);
    lit("ld_dreq_cycles", 32'(c_dreq - s_dreq), 32'd3);
    lit("ld_we_cycles", 32'(c_we - s_we), 32'd0);
    lit("ld_waddr_sel", 32'({last_wa, last_ws}), 32'hB);

    // LD whose ack lands on the timeout cycle: ack wins
    snap(); run_instr(24'hA1230F, 0, TO, 0, h);
    lit("ld255_err", 32'(mem_err), 32'd0);
    lit("ld255_rfwe", 32'(c_rfwe - s_rfwe), 32'd1);
    lit("ld255_dreq", 32'(c_dreq - s_dreq), 32'd255);

    // JMP Ra=7
    snap(); run_instr(24'h707000, 0, 0, 0, h);
    lit("jmp_load", 32'(c_ld - s_ld), 32'd1);
    lit("jmp_inc", 32'(c_inc - s_inc), 32'd0);
    lit("jmp_fetch_next", 32'(imem_req), 32'd1);

    // Reserved opcode 0xF
    snap(); run_instr(24'hF00000, 2, 0, 0, h);
    lit("rsv_ireq", 32'(c_ireq - s_ireq), 32'd3);
`ifdef ILLEGAL_TRAP_EN
    lit("rsv_halt", 32'({state_o, trap}), 32'hD);
    apply_reset();
`else
    lit("rsv_inc", 32'(c_inc - s_inc), 32'd1);
    lit("rsv_fetch_continues", 32'(imem_req), 32'd1);
`endif

    // ST that never acks
    snap(); run_instr(24'hB00306, 0, 0, 0, h);
    lit("st_dreq", 32'(c_dreq - s_dreq), 32'd255);
    lit("st_we", 32'(c_we - s_we), 32'd255);
    lit("st_inc", 32'(c_inc - s_inc), 32'd1);
    lit("st_rfwe", 32'(c_rfwe - s_rfwe), 32'd0);
    lit("st_err", 32'(mem_err), 32'd1);
    run_instr(24'h045600, 1, 0, 0, h);
    lit("err_sticky", 32'(mem_err), 32'd1);

    // Reset while a load is waiting in MEM
    run_instr(24'hA01102, 0, 0, 2, h);
    lit("mem_abort_dreq", 32'(dmem_req), 32'd1);
    apply_reset();

    // Randomised instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [23:0] ins;
      int md;
      ins = rnd24();
      md = ($urandom_range(0, 39) == 0) ? 0 : int'($urandom_range(1, 6));
      run_instr(ins, int'($urandom_range(0, 3)), md, 0, h);
      if (h) apply_reset();
    end

    @(negedge clk);
    lit("trace_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
